// File: rtl/point_mult_ctrl_if.sv
// rtl/point_mult_ctrl_if.sv - host and point-unit signal bundle for point_mult_ctrl
interface point_mult_ctrl_if #(
  parameter int KW = 256,
  parameter int CW = 256
);
  // Points are packed as {x, y}, each coordinate CW bits wide.
  localparam int PW = 2 * CW;

  // host side
  logic          start;
  logic [KW-1:0] k;
  logic [PW-1:0] P_in;
  logic          busy;
  logic          done;
  logic [PW-1:0] R_out;
  logic          R_inf;
  logic          err;

  // point_add unit
  logic [PW-1:0] add_P;
  logic [PW-1:0] add_Q;
  logic          add_reset;
  logic          add_done;
  logic [PW-1:0] add_R;

  // point_double unit
  logic [PW-1:0] dbl_P;
  logic          dbl_reset;
  logic          dbl_done;
  logic [PW-1:0] dbl_R;

  // controller view
  modport slave (
    input  start, k, P_in, add_done, add_R, dbl_done, dbl_R,
    output busy, done, R_out, R_inf, err, add_P, add_Q, add_reset, dbl_P, dbl_reset
  );

  // host plus point-unit view
  modport master (
    output start, k, P_in, add_done, add_R, dbl_done, dbl_R,
    input  busy, done, R_out, R_inf, err, add_P, add_Q, add_reset, dbl_P, dbl_reset
  );
endinterface

// File: rtl/point_mult_ctrl.sv
// rtl/point_mult_ctrl.sv - left-to-right double-and-add sequencer for R = k*P
module point_mult_ctrl #(
  parameter int              KW      = 256,
  parameter int              CW      = 256,
  parameter int              TO_W    = 20,
  parameter logic [TO_W-1:0] TIMEOUT = {TO_W{1'b1}}
) (
  input  logic               clk,
  input  logic               Reset,
  point_mult_ctrl_if.slave   bus
);
  localparam int PW = 2 * CW;
  localparam int IW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [3:0] {
    IDLE, SCAN, DBL_LAUNCH, DBL_WAIT, BITCHK, ADD_LAUNCH, ADD_WAIT, NEXT, FIN
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [PW-1:0]   base_q, base_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic            acc_inf_q, acc_inf_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            dbl2_q, dbl2_d;   // doubling launched from BITCHK (acc == base)
  logic            err_q, err_d;
  logic [PW-1:0]   r_out_q, r_out_d;
  logic            r_inf_q, r_inf_d;

  // Units see registered operands; each unit runs only in its own WAIT state.
  assign bus.add_P     = acc_q;
  assign bus.add_Q     = base_q;
  assign bus.dbl_P     = acc_q;
  assign bus.add_reset = (state_q != ADD_WAIT);
  assign bus.dbl_reset = (state_q != DBL_WAIT);
  assign bus.busy      = (state_q != IDLE) && (state_q != FIN);
  assign bus.done      = (state_q == FIN);
  assign bus.R_out     = r_out_q;
  assign bus.R_inf     = r_inf_q;
  assign bus.err       = err_q;

  // Next-state logic; results are loaded on entry to FIN so they line up with done.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    base_d    = base_q;
    acc_d     = acc_q;
    acc_inf_d = acc_inf_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dbl2_d    = dbl2_q;
    err_d     = err_q;
    r_out_d   = r_out_q;
    r_inf_d   = r_inf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_d       = bus.k;
          base_d    = bus.P_in;
          acc_d     = '0;
          acc_inf_d = 1'b1;
          idx_d     = IW'(KW - 1);
          err_d     = 1'b0;
          r_out_d   = '0;
          r_inf_d   = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (acc_inf_q) begin
          state_d = BITCHK;
        end else begin
          dbl2_d  = 1'b0;
          state_d = DBL_LAUNCH;
        end
      end
      DBL_LAUNCH: begin
        cnt_d   = '0;
        state_d = DBL_WAIT;
      end
      DBL_WAIT: begin
        // cnt_q == 0 marks the first wait cycle, where Done is not trusted.
        if (bus.dbl_done && (cnt_q != '0)) begin
          acc_d = bus.dbl_R;
          if (bus.dbl_R[CW-1:0] == '0) acc_inf_d = 1'b1;
          state_d = dbl2_q ? NEXT : BITCHK;
        end else if (cnt_q == TIMEOUT) begin
          err_d   = 1'b1;
          r_out_d = '0;
          r_inf_d = 1'b0;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BITCHK: begin
        if (!k_q[idx_q]) begin
          state_d = NEXT;
        end else if (acc_inf_q) begin
          acc_d     = base_q;
          acc_inf_d = 1'b0;
          state_d   = NEXT;
        end else if (acc_q == base_q) begin
          dbl2_d  = 1'b1;
          state_d = DBL_LAUNCH;
        end else if (acc_q[PW-1:CW] == base_q[PW-1:CW]) begin
          acc_inf_d = 1'b1;      // acc == -base
          state_d   = NEXT;
        end else begin
          state_d = ADD_LAUNCH;
        end
      end
      ADD_LAUNCH: begin
        cnt_d   = '0;
        state_d = ADD_WAIT;
      end
      ADD_WAIT: begin
        if (bus.add_done && (cnt_q != '0)) begin
          acc_d   = bus.add_R;
          state_d = NEXT;
        end else if (cnt_q == TIMEOUT) begin
          err_d   = 1'b1;
          r_out_d = '0;
          r_inf_d = 1'b0;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NEXT: begin
        if (idx_q == '0) begin
          r_out_d = acc_inf_q ? '0 : acc_q;
          r_inf_d = acc_inf_q;
          state_d = FIN;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = SCAN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      acc_inf_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      dbl2_q    <= 1'b0;
      err_q     <= 1'b0;
      r_out_q   <= '0;
      r_inf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      base_q    <= base_d;
      acc_q     <= acc_d;
      acc_inf_q <= acc_inf_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dbl2_q    <= dbl2_d;
      err_q     <= err_d;
      r_out_q   <= r_out_d;
      r_inf_q   <= r_inf_d;
    end
  end
endmodule

// File: doc/point_mult_ctrl.md
Name: point_mult_ctrl

Overview:
- Sequencer for scalar point multiplication R = k·P. Left-to-right double-and-add over scalar bits.
- Owns one point_add instance and one point_double instance: drives their operands and reset-to-start inputs, waits on their Done, and captures results.
- Tracks the point at infinity and degenerate add cases, which the add/double units cannot represent.
- Sits between top-level protocol logic (ECDH/ECDSA) and the point-operation units.

Parameters:
- KW, 256, scalar width in bits.
- TO_W, 20, width of the per-operation timeout counter.
- TIMEOUT, 20'hFFFFF, maximum cycles allowed waiting for a unit's Done before err.

Ports:
- clk  input  1  clock
- Reset  input  1  synchronous active-low reset (asserted when 0)
- start  input  1  1-cycle request; sampled only in IDLE
- k  input  KW  scalar; captured on accepted start
- P_in  input  curve_point_t (512)  base point; captured on accepted start
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  1-cycle pulse when the result is valid
- R_out  output  curve_point_t  result; holds until next accepted start
- R_inf  output  1  result is the point at infinity (R_out = 0)
- err  output  1  a unit timed out; valid with done
- add_P, add_Q  output  curve_point_t  point_add operands (acc, base)
- add_reset  output  1  active-high hold/restart for point_add
- add_done  input  1  point_add Done
- add_R  input  curve_point_t  point_add result
- dbl_P  output  curve_point_t  point_double operand (acc)
- dbl_reset  output  1  active-high hold/restart for point_double
- dbl_done  input  1  point_double Done
- dbl_R  input  curve_point_t  point_double result

Behaviour:
- Reset (Reset=0 at clk edge):
  - State = IDLE.
  - busy=0, done=0, err=0, R_inf=0, R_out=0.
  - add_reset=1, dbl_reset=1.
  - Internal acc, acc_inf, bit index and timeout counter cleared.
  - Reset mid-operation aborts immediately; no done pulse.
- Unit operands are registered: acc, and base = captured P_in. Units are held in reset (add_reset/dbl_reset=1) in every state except their own WAIT state.
- States:
  - IDLE: on start, capture k and P_in; acc_inf=1, idx=KW-1, err=0 → SCAN. Start is ignored when not in IDLE.
  - SCAN: if acc_inf=0 → DBL_LAUNCH; else → BITCHK.
  - DBL_LAUNCH: 1 cycle with dbl_reset=1 and operands stable; clear timeout counter → DBL_WAIT.
  - DBL_WAIT: dbl_reset=0. dbl_done is ignored during the first cycle of the state. On dbl_done=1: acc ← dbl_R. If dbl_R.y==0 (2-torsion result), acc_inf ← 1. Then → BITCHK.
  - BITCHK, bit k[idx]=0: → NEXT.
  - BITCHK, bit=1 and acc_inf=1: acc ← base, acc_inf ← 0, no unit launched → NEXT.
  - BITCHK, bit=1, acc==base: → DBL2_LAUNCH (identical to DBL_LAUNCH/DBL_WAIT, then returns to NEXT).
  - BITCHK, bit=1, acc.x==base.x with y different: acc_inf ← 1 → NEXT.
  - BITCHK, bit=1, all other cases: → ADD_LAUNCH.
  - ADD_LAUNCH / ADD_WAIT: same rules as the DBL states, using add_reset/add_done. On add_done: acc ← add_R → NEXT.
  - NEXT: if idx==0 → FIN; else idx ← idx-1 → SCAN.
  - FIN: R_out ← acc (0 if acc_inf), R_inf ← acc_inf, done=1 for this cycle, busy=0 → IDLE.
- Timeout:
  - In any WAIT state the counter increments every cycle.
  - When the count reaches TIMEOUT without Done: err ← 1, R_out ← 0, R_inf ← 0 → FIN.
- k=0: R_inf=1, done after KW BITCHK/NEXT passes; no unit is ever launched.
- Done is sampled only in WAIT states. A stale Done from a previous operation cannot be consumed because the unit is held in reset for at least 1 cycle before each WAIT.
- Done latency (bits scanned below the MSB set bit, no degenerate cases): IDLE→done = 1 + Σ per-bit cycles.
  - Per-bit cycles = (SCAN + BITCHK + NEXT) + doubling (2 + Tdbl) + addition if bit=1 (2 + Tadd).
  - Tdbl and Tadd are the cycles each unit takes after its reset is released until Done.

Test Plan:
- k=0, P arbitrary → done once; R_inf=1; R_out=0; zero add/dbl launches; busy high exactly until done.
- k=1, P=(x=5,y=7) stub units → R_out=(5,7), R_inf=0, no launches; k=2 → exactly 1 double, R_out=stub dbl_R.
- k=5 (101b), stub units with latency 10 (add) and 6 (dbl) → launch order dbl, dbl, add. Bench models the total done latency from the formula and checks it exactly.
- k=3 on a small-curve reference model (e.g. y²=x³+x+1 over the bench field): force acc.x==base.x with y differing → no add launched, R_inf=1. Force acc==base → doubling path taken instead of add.
- add_done stuck low, TIMEOUT=100 → err=1 and done exactly 102 cycles after ADD_LAUNCH; R_out=0.
- Reset=0 for 1 cycle mid-DBL_WAIT → outputs return to reset values, no done pulse. Start during busy is ignored; a new start after reset completes normally.
